// File: rtl/mem_stream_loader_if.sv
// Byte-stream handshake bundle between a host and mem_stream_loader.
// rx_* carries command/payload bytes into the loader, tx_* carries read-back bytes out.
interface mem_stream_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Host side: produces RX bytes, consumes TX bytes
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  // Loader side: consumes RX bytes, produces TX bytes
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_stream_loader.sv
// Byte-stream command engine in front of memory_manager.
// Frame: CMD, A0, A1, A2, L0, L1 (LSB first), then payload for writes.
// CMD 0x01 writes payload to consecutive addresses, CMD 0x02 streams bytes back on TX.
// The memory data bus is bidirectional and is only driven while mem_wren is high.
module mem_stream_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 23,
  parameter int LEN_WIDTH     = 16,
  parameter int WR_CYCLES     = 2,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_stream_loader_if.slave       host,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_wren,
  output logic                     busy,
  output logic                     err
);

  localparam int HOLD_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h01);
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h02);

  typedef enum logic [3:0] {
    IDLE,
    HDR_A0,
    HDR_A1,
    HDR_A2,
    HDR_L0,
    HDR_L1,
    WR_WAIT,
    WR_HOLD,
    RD_ISSUE,
    RD_WAIT,
    RD_SEND
  } state_t;

  state_t                   state;
  logic                     is_write;
  logic [DATA_WIDTH-1:0]    a0;
  logic [DATA_WIDTH-1:0]    a1;
  logic [DATA_WIDTH-1:0]    len_lo;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]     remaining;
  logic [LEN_WIDTH-1:0]     hdr_len;
  logic [HOLD_W-1:0]        hold_cnt;
  logic [LAT_W-1:0]         lat_cnt;
  logic                     rx_hs;
  logic                     tx_hs;

  assign rx_hs   = host.rx_valid && host.rx_ready;
  assign tx_hs   = host.tx_valid && host.tx_ready;
  assign hdr_len = LEN_WIDTH'({host.rx_data, len_lo});

  // The bus is released whenever no write is in progress so memory_manager can drive reads
  assign mem_data = mem_wren ? wr_data : {DATA_WIDTH{1'bz}};

  // Capture header and payload bytes; these are pure data and carry no reset
  always_ff @(posedge clk) begin
    if (rx_hs) begin
      case (state)
        HDR_A0:  a0      <= host.rx_data;
        HDR_A1:  a1      <= host.rx_data;
        HDR_L0:  len_lo  <= host.rx_data;
        WR_WAIT: wr_data <= host.rx_data;
        default: ;
      endcase
    end
  end

  // Command FSM with registered handshake, memory and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      host.rx_ready <= 1'b0;
      host.tx_valid <= 1'b0;
      host.tx_data  <= '0;
      mem_address   <= '0;
      mem_wren      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      cur_addr      <= '0;
      remaining     <= '0;
      hold_cnt      <= '0;
      lat_cnt       <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          host.rx_ready <= 1'b1;
          if (rx_hs) begin
            if (host.rx_data == CMD_WRITE || host.rx_data == CMD_READ) begin
              is_write <= (host.rx_data == CMD_WRITE);
              busy     <= 1'b1;
              state    <= HDR_A0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        HDR_A0: if (rx_hs) state <= HDR_A1;
        HDR_A1: if (rx_hs) state <= HDR_A2;

        HDR_A2: begin
          if (rx_hs) begin
            // Address bits above ADDRESS_WIDTH in the third byte are dropped
            cur_addr <= ADDRESS_WIDTH'({host.rx_data, a1, a0});
            state    <= HDR_L0;
          end
        end

        HDR_L0: if (rx_hs) state <= HDR_L1;

        HDR_L1: begin
          if (rx_hs) begin
            remaining <= hdr_len;
            if (hdr_len == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (is_write) begin
              state <= WR_WAIT;
            end else begin
              host.rx_ready <= 1'b0;
              mem_address   <= cur_addr;
              state         <= RD_ISSUE;
            end
          end
        end

        WR_WAIT: begin
          if (rx_hs) begin
            host.rx_ready <= 1'b0;
            mem_address   <= cur_addr;
            mem_wren      <= 1'b1;
            hold_cnt      <= HOLD_W'(WR_CYCLES - 1);
            state         <= WR_HOLD;
          end
        end

        WR_HOLD: begin
          if (hold_cnt == '0) begin
            mem_wren      <= 1'b0;
            cur_addr      <= cur_addr + ADDRESS_WIDTH'(1);
            remaining     <= remaining - LEN_WIDTH'(1);
            host.rx_ready <= 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= WR_WAIT;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        RD_ISSUE: begin
          lat_cnt <= LAT_W'(READ_LATENCY - 1);
          state   <= RD_WAIT;
        end

        RD_WAIT: begin
          if (lat_cnt == '0) begin
            host.tx_data  <= mem_data;
            host.tx_valid <= 1'b1;
            state         <= RD_SEND;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        RD_SEND: begin
          if (tx_hs) begin
            host.tx_valid <= 1'b0;
            cur_addr      <= cur_addr + ADDRESS_WIDTH'(1);
            remaining     <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              busy          <= 1'b0;
              host.rx_ready <= 1'b1;
              state         <= IDLE;
            end else begin
              mem_address <= cur_addr + ADDRESS_WIDTH'(1);
              state       <= RD_ISSUE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
